// File: rtl/fifo_ctrl_pkg.sv
// Shared types and command-word field positions for the multi-channel FIFO controller.
package fifo_ctrl_pkg;

   // Read-burst sequencer states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_GAP   = 2'd2
   } rd_state_t;

   // Command word bit positions
   localparam int RD_BIT  = 0;
   localparam int LEN_LSB = 8;
   localparam int LEN_W   = 8;
   localparam int RST_BIT = 16;
   localparam int CLR_BIT = 17;
   localparam int CH_LSB  = 20;
   localparam int CH_W    = 4;

   localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/fifo_alarm_bit.sv
// One sticky full-alarm bit: set dominates clear, holds otherwise.
module fifo_alarm_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic set,
   input  logic clr,
   output logic alarm
);

   // Sticky flag with set priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    alarm <= 1'b0;
      else if (set)  alarm <= 1'b1;
      else if (clr)  alarm <= 1'b0;
   end

endmodule

// File: rtl/fifo_ctrl_mc.sv
// Multi-channel FIFO controller: decodes SPI command words into per-channel
// FIFO resets, alarm clears and paced read bursts.
module fifo_ctrl_mc
   import fifo_ctrl_pkg::*;
#(
   parameter int NCH = 4,
   parameter int DW  = 32,
   parameter int GAP = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [DW-1:0]  din,
   input  logic           wclk,
   input  logic [NCH-1:0] fullflag,
   input  logic [NCH-1:0] emptyflag,
   output logic [NCH-1:0] fifo_rclk,
   output logic [NCH-1:0] fifo_rst,
   output logic [NCH-1:0] fullflag_alarm,
   output logic           busy,
   output logic [7:0]     rd_count
);

   localparam logic [4:0] NCH5     = 5'(NCH);
   localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   logic             wclk_q;
   logic             acc;
   logic             cmd_rd, cmd_rst, cmd_clr, cmd_ok;
   logic [LEN_W-1:0] cmd_len;
   logic [CH_W-1:0]  cmd_ch;
   logic [NCH-1:0]   cmd_oh, act_oh, alarm_clr;
   logic             empty_act, start, kill;

   rd_state_t        state, state_n;
   logic [CH_W-1:0]  ch_q, ch_n;
   logic [7:0]       left_q, left_n;
   logic [3:0]       gap_q, gap_n;
   logic [7:0]       cnt_n;

   // Bits of din outside the command fields are intentionally ignored
   logic [DW-1:0]    din_unused;
   assign din_unused = din;

   // Command accepted only on the first cycle of a wclk high level
   assign acc     = wclk & ~wclk_q;
   assign cmd_rd  = din[RD_BIT];
   assign cmd_rst = din[RST_BIT];
   assign cmd_clr = din[CLR_BIT];
   assign cmd_len = din[LEN_LSB +: LEN_W];
   assign cmd_ch  = din[CH_LSB +: CH_W];
   assign cmd_ok  = acc & ({1'b0, cmd_ch} < NCH5);
   assign cmd_oh  = NCH'(1) << cmd_ch;
   assign act_oh  = NCH'(1) << ch_q;

   assign empty_act = |(emptyflag & act_oh);
   // Reset takes precedence over read in the same word; reads while busy are dropped
   assign start     = cmd_ok & cmd_rd & ~cmd_rst & (state == S_IDLE);
   assign kill      = cmd_ok & cmd_rst & (state != S_IDLE) & (cmd_ch == ch_q);
   assign alarm_clr = (cmd_ok & (cmd_rst | cmd_clr)) ? cmd_oh : '0;
   assign busy      = (state != S_IDLE);

   // State, burst bookkeeping, edge history and the registered reset pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ch_q     <= '0;
         left_q   <= '0;
         gap_q    <= '0;
         rd_count <= '0;
         wclk_q   <= 1'b0;
         fifo_rst <= '0;
      end else begin
         state    <= state_n;
         ch_q     <= ch_n;
         left_q   <= left_n;
         gap_q    <= gap_n;
         rd_count <= cnt_n;
         wclk_q   <= wclk;
         fifo_rst <= (cmd_ok & cmd_rst) ? cmd_oh : '0;
      end
   end

   // Burst sequencing: next state, counters and the read pulse
   always_comb begin
      state_n   = state;
      ch_n      = ch_q;
      left_n    = left_q;
      gap_n     = gap_q;
      cnt_n     = rd_count;
      fifo_rclk = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_PULSE;
               ch_n    = cmd_ch;
               left_n  = (cmd_len == '0) ? 8'd1 : cmd_len;
               cnt_n   = '0;
            end
         end
         S_PULSE: begin
            // An empty FIFO aborts the burst without a pulse
            if (empty_act) begin
               state_n = S_IDLE;
            end else begin
               fifo_rclk = act_oh;
               if (rd_count != CNT_MAX) cnt_n = rd_count + 8'd1;
               left_n = left_q - 8'd1;
               if (left_q == 8'd1) begin
                  state_n = S_IDLE;
               end else if (GAP == 0) begin
                  state_n = S_PULSE;
               end else begin
                  state_n = S_GAP;
                  gap_n   = '0;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_n = S_PULSE;
            else                   gap_n   = gap_q + 4'd1;
         end
         default: state_n = S_IDLE;
      endcase
      // A FIFO reset aimed at the active channel ends the burst
      if (kill) state_n = S_IDLE;
   end

   // Per-channel sticky full alarms
   for (genvar g = 0; g < NCH; g++) begin : g_alarm
      fifo_alarm_bit u_alarm (
         .clk   (clk),
         .rst_n (rst_n),
         .set   (fullflag[g]),
         .clr   (alarm_clr[g]),
         .alarm (fullflag_alarm[g])
      );
   end

endmodule

// File: doc/fifo_ctrl_mc.md
FIFO_CTRL_MC -- requirements
Module: fifo_ctrl_mc

Interface
REQ-001 Parameter NCH, default 4: number of FIFO channels served (1..16).
REQ-002 Parameter DW, default 32: command word width (at least 24).
REQ-003 Parameter GAP, default 1: idle clk cycles between successive read pulses in a burst (0..15).
REQ-004 Port clk, input, 1: single clock; all logic is rising-edge clocked on clk.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port din, input, DW: command word; valid while wclk is high.
REQ-007 Port wclk, input, 1: SPI write strobe (level), synchronous to clk.
REQ-008 Port fullflag, input, NCH: per-channel FIFO full.
REQ-009 Port emptyflag, input, NCH: per-channel FIFO empty.
REQ-010 Port fifo_rclk, output, NCH: per-channel one-cycle read pulse.
REQ-011 Port fifo_rst, output, NCH: per-channel one-cycle FIFO reset pulse.
REQ-012 Port fullflag_alarm, output, NCH: per-channel sticky full alarm.
REQ-013 Port busy, output, 1: read burst in progress.
REQ-014 Port rd_count, output, 8: read pulses issued in the current or last burst.

Function
REQ-015 A command SHALL be accepted only on the first clk cycle wclk is high (rising-edge detect via a registered copy of wclk); a held-high wclk SHALL NOT re-trigger.
REQ-016 Command fields SHALL be: din[0] read, din[15:8] burst length LEN, din[16] FIFO reset, din[17] alarm clear, din[23:20] channel CH; other bits ignored.
REQ-017 A command with CH >= NCH SHALL be discarded entirely.
REQ-018 FIFO reset: fifo_rst[CH] SHALL be high exactly one cycle, the cycle after acceptance.
REQ-019 Read FSM states SHALL be IDLE, PULSE and GAP; reset state is IDLE.
REQ-020 IDLE->PULSE on an accepted read command with din[16]=0; LEN=0 SHALL mean 1 pulse, otherwise LEN pulses; busy SHALL be high in PULSE and GAP.
REQ-021 In PULSE, fifo_rclk[CH] SHALL be high one cycle if emptyflag[CH]=0, and rd_count SHALL increment; the first pulse SHALL occur the cycle after acceptance.
REQ-022 PULSE SHALL go to GAP (GAP>0) or back to PULSE (GAP=0); GAP SHALL last exactly GAP cycles.
REQ-023 If emptyflag[CH]=1 when entering PULSE, no pulse SHALL be issued and the FSM SHALL go to IDLE.
REQ-024 The FSM SHALL go to IDLE after the final pulse, or on any accepted FIFO reset command for the active channel.
REQ-025 A read command accepted while busy SHALL be ignored; reset and clear commands while busy SHALL still execute.
REQ-026 A command with both read and reset bits set SHALL perform only the reset.
REQ-027 rd_count SHALL clear to 0 on each new burst start and saturate at 255.
REQ-028 fullflag_alarm[i] SHALL set the cycle after fullflag[i] is sampled high and SHALL stay set.
REQ-029 fullflag_alarm[i] SHALL clear on an accepted reset or clear command addressing channel i.
REQ-030 If fullflag[i] is high in the same cycle as a clear, set SHALL win.
REQ-031 At most one fifo_rclk bit and one fifo_rst bit SHALL be high in any cycle.

Reset
REQ-032 rst_n low SHALL immediately force: FSM to IDLE; fifo_rclk, fifo_rst and fullflag_alarm to 0; busy to 0; rd_count to 0; the wclk history register to 0.
REQ-033 Reset mid-burst SHALL abandon the burst with no further pulses after release.
REQ-034 A wclk already high at reset release SHALL be accepted as a command on the first clk cycle after release.

Structure
REQ-035 Package fifo_ctrl_pkg SHALL hold the FSM state type and the command bit-position constants (RD_BIT, LEN_LSB, RST_BIT, CLR_BIT, CH_LSB).
REQ-036 Sub-module fifo_alarm_bit SHALL implement one sticky alarm bit with set-priority and SHALL be instantiated NCH times.

Verification
REQ-037 Single read on CH=2 (wclk high 3 cycles, din=0x0020_0001): exactly one pulse on fifo_rclk[2], one cycle after acceptance; rd_count=1.
REQ-038 Burst with LEN=4, GAP=1, CH=0: pulses on cycles +1, +3, +5, +7; busy falls after the last pulse; rd_count=4.
REQ-039 Burst with LEN=10 on CH=1, emptyflag[1] rising after the 3rd pulse: 3 pulses, then IDLE; rd_count=3.
REQ-040 fullflag[3] high for 1 cycle: alarm[3]=1 and held. Clear command (din[17]=1, CH=3): alarm[3]=0. Clear issued with fullflag[3] high in the same cycle: alarm[3] stays 1.
REQ-041 Reset command on CH=0 during a LEN=8 burst: fifo_rst[0] pulses once, no further rclk pulses, busy=0; a command with CH=7 when NCH=4: no output activity.
REQ-042 rst_n asserted mid-burst: all outputs 0 asynchronously; after release with wclk low, no activity.
